// File: rtl/phy_rx_deserializer.sv
// Per-lane serial-to-parallel receiver: hunts for COM alignment, confirms it with
// SYNC_COUNT consecutive aligned COM bytes, then delivers bytes with COM treated as idle fill.
module phy_rx_deserializer #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam logic [3:0] SyncTarget = 4'(SYNC_COUNT);

  typedef enum logic [1:0] {StHunt, StSync, StActive} state_e;

  state_e     state_q, state_d;
  logic [6:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       active_q, active_d;

  logic [7:0] win;
  logic       is_com;
  logic       boundary;
  logic [3:0] com_inc;

  // Window includes the bit being sampled this cycle.
  assign win      = {sr_q, data_in};
  assign is_com   = (win == COM);
  assign boundary = (bit_cnt_q == 3'd7);
  assign com_inc  = com_cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    sr_d      = win[6:0];
    bit_cnt_d = bit_cnt_q + 3'd1;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;

    unique case (state_q)
      StHunt: begin
        bit_cnt_d = 3'd0;
        if (is_com) begin
          if (SyncTarget == 4'd1) begin
            state_d = StActive;
          end else begin
            state_d   = StSync;
            com_cnt_d = 4'd1;
          end
        end
      end
      StSync: begin
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_inc;
            if (com_inc == SyncTarget) state_d = StActive;
          end else begin
            state_d   = StHunt;
            com_cnt_d = 4'd0;
          end
        end
      end
      StActive: begin
        if (boundary) begin
          strobe_d = 1'b1;
          if (is_com) begin
            valid_d = 1'b0;
          end else begin
            data_d  = win;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = StHunt;
    endcase

    active_d = (state_d == StActive);
  end

  always_ff @(posedge clk32f) begin
    if (!reset) begin
      state_q   <= StHunt;
      sr_q      <= 7'd0;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule

// File: doc/phy_rx_deserializer.md
# phy_rx_deserializer

Receive-side serial-to-parallel lane converter for the PCIe physical-layer datapath. It samples one serial bit per clk32f cycle, MSB first, and finds byte alignment by hunting for the COM symbol. Once it has seen SYNC_COUNT consecutive aligned COM bytes it declares the lane active and delivers 8-bit bytes with a valid flag. COM bytes in active mode are treated as idle fill (valid low). One instance sits per lane, between the serial link and the lane un-striping logic.

## Interface
- COM, 8'hBC: comma/idle symbol used for alignment and idle fill
- SYNC_COUNT, 4: consecutive aligned COM bytes required to enter ACTIVE; legal range 1..15
- clk32f  input  1  bit clock; all logic on posedge
- reset  input  1  synchronous, active-low; sampled on posedge clk32f
- data_in  input  1  serial bit, MSB of each byte first
- data_out  output  8  last received non-COM byte
- valid_out  output  1  high for one byte period after a non-COM byte in ACTIVE
- byte_strobe  output  1  one-cycle pulse at each aligned byte boundary in ACTIVE
- active  output  1  high while FSM is in ACTIVE

## Operation
- Shift register: every cycle, sr <= {sr[6:0], data_in}. Let win = {sr[6:0], data_in}, the 8-bit window including the current bit.
- Registers: bit_cnt (3 bits), com_cnt (4 bits), and state in {HUNT, SYNC, ACTIVE}.
- HUNT: checks win every cycle, i.e. bit-by-bit sliding search.
  - On win == COM with SYNC_COUNT == 1: go to ACTIVE.
  - On win == COM otherwise: go to SYNC; com_cnt <= 1.
  - In both cases bit_cnt <= 0.
  - Otherwise stay in HUNT.
- SYNC and ACTIVE: bit_cnt increments mod 8 every cycle. A byte boundary is the cycle with bit_cnt == 7, and win is the completed byte.
- SYNC, at a byte boundary:
  - win == COM: com_cnt + 1. If that equals SYNC_COUNT, go to ACTIVE; otherwise store it.
  - win != COM: back to HUNT; com_cnt <= 0. Sliding search resumes on the next cycle.
- ACTIVE, at a byte boundary, byte_strobe <= 1 and:
  - win != COM: data_out <= win; valid_out <= 1.
  - win == COM: valid_out <= 0; data_out holds.
- ACTIVE, off a byte boundary: byte_strobe <= 0. valid_out and data_out hold for the whole byte period.
- ACTIVE is left only by reset. There is no loss-of-sync detection.
- Reset (reset == 0 at posedge), which overrides everything including mid-byte and mid-SYNC:
  - state <= HUNT; sr, bit_cnt, com_cnt <= 0
  - data_out <= 8'h00; valid_out, byte_strobe, active <= 0
- All outputs are registered. active is high exactly when state == ACTIVE after the edge.

## Timing
- Alignment: the first COM is detected at the edge that samples its LSB. Each following COM completes 8 cycles later.
  - With SYNC_COUNT = 4, active rises at the edge that samples the LSB of the 4th consecutive COM, i.e. 24 cycles after the first COM detect.
  - Minimum = 32 serial bits after the first COM MSB.
- Data latency: data_out, valid_out and byte_strobe update at the same edge that samples the byte's LSB, so they are visible in the following cycle.
- byte_strobe: high exactly 1 cycle in 8 while active.
- A COM-like pattern straddling two bytes in ACTIVE is ignored, because alignment is frozen.
- In HUNT, a false COM match across byte edges is accepted. The SYNC check filters it: the next aligned byte must be COM.
- Reset released mid-stream: hunting starts at the first cycle with reset == 1. Bits sampled during reset do not count toward the window; sr is zeroed.

## Test plan
- Reset: hold reset = 0 for 6 cycles with random data_in -> data_out = 8'h00; valid_out, byte_strobe, active = 0 throughout.
- Clean lock: after reset, send 3 random bits, then 4×8'hBC, then 8'hFF, 8'hEE -> active rises on the LSB of the 4th BC. data_out = FF with valid_out = 1 after the next 8 bits, then EE 8 cycles later. byte_strobe pulses every 8 cycles.
- Idle fill: in ACTIVE send 8'hDD, 8'hBC, 8'hCC -> valid_out is 1, then 0, then 1. data_out stays DD during the BC period, then becomes CC.
- Sync abort: send 2×BC, 8'h55, then 4×BC, 8'h88 -> no active after 55 (returns to HUNT). active rises after the 4 later BCs; then data_out = 88.
- Misaligned false comma: the stream 0x5E,0x00 (bits contain BC shifted by 1) followed by a non-COM byte -> enters SYNC, then returns to HUNT; active stays 0.
- Reset mid-operation: in ACTIVE with data_out = 8'hAA, drive reset = 0 for 1 cycle mid-byte -> next cycle all outputs are 0 and the FSM is in HUNT. Relock needs 4 fresh BCs.
